// File: rtl/dmem_responder.sv
// Data-memory responder: MEM-stage load/store slave with programmable latency,
// funct3 width handling (byte lanes for stores, sign/zero extension for loads)
// and an error response for misaligned, out-of-range or bad-mode requests.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [2:0]  req_mode_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned OOR_SH   = IDX_W + 2;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam bit          HAS_WAIT = (LATENCY > 1);

  localparam logic [2:0] MODE_B  = 3'b000;
  localparam logic [2:0] MODE_H  = 3'b001;
  localparam logic [2:0] MODE_W  = 3'b010;
  localparam logic [2:0] MODE_BU = 3'b100;
  localparam logic [2:0] MODE_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [2:0]       mode_q, mode_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic [31:0]      mem_q [DEPTH_WORDS];

  logic             enter_resp_c;
  logic             acc_we_c;
  logic [31:0]      acc_addr_c;
  logic [31:0]      acc_wdata_c;
  logic [2:0]       acc_mode_c;
  logic [IDX_W-1:0] idx_c;
  logic             oor_c;
  logic             bad_mode_c;
  logic             misalign_c;
  logic             err_c;
  logic [31:0]      word_c;
  logic [7:0]       byte_c;
  logic [15:0]      half_c;
  logic [31:0]      load_c;
  logic [31:0]      rdata_c;
  logic [3:0]       be_c;
  logic [31:0]      wlane_c;
  logic [31:0]      wr_word_c;
  logic             commit_c;

  assign req_ready_o = ready_q;
  assign rsp_valid_o = valid_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

  // Access operands: a LATENCY=1 access happens on the acceptance edge, so
  // operands come straight from the request; otherwise from the latched copy.
  always_comb begin
    acc_we_c    = we_q;
    acc_addr_c  = addr_q;
    acc_wdata_c = wdata_q;
    acc_mode_c  = mode_q;
    if (state_q == IDLE) begin
      acc_we_c    = req_we_i;
      acc_addr_c  = req_addr_i;
      acc_wdata_c = req_wdata_i;
      acc_mode_c  = req_mode_i;
    end
  end

  // Request legality check and load-data extraction/extension.
  always_comb begin
    idx_c      = acc_addr_c[IDX_W+1:2];
    oor_c      = (acc_addr_c >> OOR_SH) != 32'd0;
    bad_mode_c = 1'b0;
    misalign_c = 1'b0;
    word_c     = mem_q[idx_c];
    byte_c     = 8'(word_c >> {acc_addr_c[1:0], 3'b000});
    half_c     = acc_addr_c[1] ? word_c[31:16] : word_c[15:0];
    load_c     = 32'd0;
    case (acc_mode_c)
      MODE_B:  load_c = {{24{byte_c[7]}}, byte_c};
      MODE_H: begin
        load_c     = {{16{half_c[15]}}, half_c};
        misalign_c = acc_addr_c[0];
      end
      MODE_W: begin
        load_c     = word_c;
        misalign_c = acc_addr_c[1:0] != 2'b00;
      end
      MODE_BU: begin
        load_c     = {24'd0, byte_c};
        bad_mode_c = acc_we_c;
      end
      MODE_HU: begin
        load_c     = {16'd0, half_c};
        misalign_c = acc_addr_c[0];
        bad_mode_c = acc_we_c;
      end
      default: bad_mode_c = 1'b1;
    endcase
    err_c   = oor_c | bad_mode_c | misalign_c;
    rdata_c = (err_c || acc_we_c) ? 32'd0 : load_c;
  end

  // Store lane enables and merged write word; unwritten lanes keep old data.
  always_comb begin
    be_c    = 4'b0000;
    wlane_c = acc_wdata_c;
    case (acc_mode_c)
      MODE_B: begin
        be_c    = 4'b0001 << acc_addr_c[1:0];
        wlane_c = {4{acc_wdata_c[7:0]}};
      end
      MODE_H: begin
        be_c    = acc_addr_c[1] ? 4'b1100 : 4'b0011;
        wlane_c = {2{acc_wdata_c[15:0]}};
      end
      MODE_W:  be_c = 4'b1111;
      default: be_c = 4'b0000;
    endcase
    for (int i = 0; i < 4; i++) begin
      wr_word_c[8*i +: 8] = be_c[i] ? wlane_c[8*i +: 8] : word_c[8*i +: 8];
    end
    commit_c = enter_resp_c && acc_we_c && !err_c;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mode_d       = mode_q;
    ready_d      = ready_q;
    valid_d      = valid_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    enter_resp_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          we_d    = req_we_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          mode_d  = req_mode_i;
          cnt_d   = CNT_LOAD;
          ready_d = 1'b0;
          if (HAS_WAIT) begin
            state_d = WAIT;
          end else begin
            state_d      = RESP;
            valid_d      = 1'b1;
            enter_resp_c = 1'b1;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d      = RESP;
          valid_d      = 1'b1;
          enter_resp_c = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
          valid_d = 1'b0;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        ready_d = 1'b1;
      end
    endcase
    if (enter_resp_c) begin
      rdata_d = rdata_c;
      err_d   = err_c;
    end
  end

  // State and control/response registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mode_q  <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mode_q  <= mode_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage array: not reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk_i) begin
    if (!rst_i && commit_c) begin
      mem_q[idx_c] <= wr_word_c;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 1, 4, 3) driven from
// a vector table plus directed stall and mid-operation reset sequences.
module tb_dmem_responder;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  mode;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  logic        clk;
  logic [2:0]  rst;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [2:0]  req_we;
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [2:0]  req_mode  [3];
  logic [2:0]  rsp_valid;
  logic [2:0]  rsp_ready;
  logic [31:0] rsp_rdata [3];
  logic [2:0]  rsp_err;

  int n_total = 0;
  int n_pass  = 0;

  vec_t vecs[$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(
      .DEPTH_WORDS(1024),
      .LATENCY    ((g == 0) ? 1 : ((g == 1) ? 4 : 3))
    ) u_dut (
      .clk_i      (clk),
      .rst_i      (rst[g]),
      .req_valid_i(req_valid[g]),
      .req_ready_o(req_ready[g]),
      .req_we_i   (req_we[g]),
      .req_addr_i (req_addr[g]),
      .req_wdata_i(req_wdata[g]),
      .req_mode_i (req_mode[g]),
      .rsp_valid_o(rsp_valid[g]),
      .rsp_ready_i(rsp_ready[g]),
      .rsp_rdata_o(rsp_rdata[g]),
      .rsp_err_o  (rsp_err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic add(input logic we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [2:0] md, input logic [31:0] rd, input logic er);
    vec_t v;
    v.we = we; v.addr = a; v.wdata = wd; v.mode = md; v.exp_rd = rd; v.exp_err = er;
    vecs.push_back(v);
  endtask

  // Issue one request from IDLE (called at a negedge), return response and latency.
  task automatic run_req(input int u, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [2:0] md,
                         output logic [31:0] rd, output logic er, output int lat);
    req_valid[u] = 1'b1;
    req_we[u]    = we;
    req_addr[u]  = a;
    req_wdata[u] = wd;
    req_mode[u]  = md;
    rsp_ready[u] = 1'b1;
    @(negedge clk);
    req_valid[u] = 1'b0;
    lat = 1;
    while (!rsp_valid[u] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rd = rsp_rdata[u];
    er = rsp_err[u];
    @(negedge clk);
    chk($sformatf("hs_valid_drop[u%0d]", u), 32'(rsp_valid[u]), 32'd0);
    chk($sformatf("hs_ready_rise[u%0d]", u), 32'(req_ready[u]), 32'd1);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          n;

  initial begin
    rst       = 3'b111;
    req_valid = '0;
    req_we    = '0;
    rsp_ready = '0;
    for (int u = 0; u < 3; u++) begin
      req_addr[u]  = '0;
      req_wdata[u] = '0;
      req_mode[u]  = '0;
    end
    repeat (3) @(negedge clk);
    rst = 3'b000;

    for (int u = 0; u < 3; u++) begin
      chk($sformatf("rst_ready[u%0d]", u), 32'(req_ready[u]), 32'd1);
      chk($sformatf("rst_valid[u%0d]", u), 32'(rsp_valid[u]), 32'd0);
      chk($sformatf("rst_rdata[u%0d]", u), rsp_rdata[u], 32'd0);
      chk($sformatf("rst_err[u%0d]", u), 32'(rsp_err[u]), 32'd0);
    end

    // Vector table for the LATENCY=1 instance.
    add(1, 32'h0000_0000, 32'h1111_1111, LW,    32'h0,         0);
    add(1, 32'h0000_0004, 32'h0404_0404, LW,    32'h0,         0);
    add(1, 32'h0000_0010, 32'hDEAD_BEEF, LW,    32'h0,         0);
    add(0, 32'h0000_0010, 32'h0,         LW,    32'hDEAD_BEEF, 0);
    add(0, 32'h0000_0013, 32'h0,         LB,    32'hFFFF_FFDE, 0);
    add(0, 32'h0000_0013, 32'h0,         LBU,   32'h0000_00DE, 0);
    add(0, 32'h0000_0012, 32'h0,         LH,    32'hFFFF_DEAD, 0);
    add(0, 32'h0000_0010, 32'h0,         LHU,   32'h0000_BEEF, 0);
    add(1, 32'h0000_0011, 32'h0000_0055, LB,    32'h0,         0);
    add(0, 32'h0000_0010, 32'h0,         LW,    32'hDEAD_55EF, 0);
    add(1, 32'h0000_0012, 32'h0000_1234, LH,    32'h0,         0);
    add(0, 32'h0000_0010, 32'h0,         LW,    32'h1234_55EF, 0);
    add(0, 32'h0000_0011, 32'h0,         LB,    32'h0000_0055, 0);
    add(0, 32'h0000_0010, 32'h0,         LH,    32'h0000_55EF, 0);
    add(0, 32'h0000_0012, 32'h0,         LBU,   32'h0000_0034, 0);
    add(0, 32'h0000_0002, 32'h0,         LW,    32'h0,         1);
    add(0, 32'h0000_0001, 32'h0,         LH,    32'h0,         1);
    add(0, 32'h0000_0011, 32'h0,         LHU,   32'h0,         1);
    add(1, 32'h0000_0006, 32'hFFFF_FFFF, LW,    32'h0,         1);
    add(0, 32'h0000_0004, 32'h0,         LW,    32'h0404_0404, 0);
    add(1, 32'h0000_0010, 32'hFFFF_FFFF, 3'b011,32'h0,         1);
    add(1, 32'h0000_0010, 32'hFFFF_FFFF, LBU,   32'h0,         1);
    add(1, 32'h0000_0013, 32'hFFFF_FFFF, LH,    32'h0,         1);
    add(0, 32'h0000_0010, 32'h0,         3'b110,32'h0,         1);
    add(0, 32'h0000_0010, 32'h0,         LW,    32'h1234_55EF, 0);
    add(1, 32'h0000_1000, 32'hCAFE_F00D, LW,    32'h0,         1);
    add(0, 32'h0000_1000, 32'h0,         LW,    32'h0,         1);
    add(0, 32'h0000_0000, 32'h0,         LW,    32'h1111_1111, 0);
    add(1, 32'h0000_0012, 32'hFFFF_FF80, LB,    32'h0,         0);
    add(0, 32'h0000_0010, 32'h0,         LW,    32'h1280_55EF, 0);
    add(0, 32'h0000_0012, 32'h0,         LB,    32'hFFFF_FF80, 0);

    foreach (vecs[i]) begin
      run_req(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].mode, rd, er, lat);
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("v%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'd1);
    end

    // LATENCY=4: response stall with a held request behind it.
    run_req(1, 1'b1, 32'h10, 32'h0000_0077, LW, rd, er, lat);
    chk("l4_sw_latency", 32'(lat), 32'd4);
    chk("l4_sw_err", 32'(er), 32'd0);
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b0;
    req_addr[1]  = 32'h10;
    req_mode[1]  = LW;
    rsp_ready[1] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("l4_stall_valid_c%0d", k), 32'(rsp_valid[1]), 32'(k >= 4));
      chk($sformatf("l4_stall_ready_c%0d", k), 32'(req_ready[1]), 32'd0);
      if (k >= 4) begin
        chk($sformatf("l4_stall_rdata_c%0d", k), rsp_rdata[1], 32'h0000_0077);
        chk($sformatf("l4_stall_err_c%0d", k), 32'(rsp_err[1]), 32'd0);
      end
    end
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    chk("l4_post_hs_valid", 32'(rsp_valid[1]), 32'd0);
    chk("l4_post_hs_ready", 32'(req_ready[1]), 32'd1);
    @(negedge clk);
    chk("l4_second_accept_ready", 32'(req_ready[1]), 32'd0);
    req_valid[1] = 1'b0;
    n = 1;
    while (!rsp_valid[1] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("l4_second_latency", 32'(n), 32'd4);
    chk("l4_second_rdata", rsp_rdata[1], 32'h0000_0077);
    @(negedge clk);
    chk("l4_second_hs_valid", 32'(rsp_valid[1]), 32'd0);

    // LATENCY=3: reset during WAIT drops an uncommitted store.
    run_req(2, 1'b1, 32'h20, 32'h0, LW, rd, er, lat);
    chk("l3_sw_latency", 32'(lat), 32'd3);
    run_req(2, 1'b1, 32'h24, 32'h5A5A_0000, LW, rd, er, lat);
    run_req(2, 1'b0, 32'h24, 32'h0, LW, rd, er, lat);
    chk("l3_lw24_rdata", rd, 32'h5A5A_0000);
    req_valid[2] = 1'b1;
    req_we[2]    = 1'b1;
    req_addr[2]  = 32'h20;
    req_wdata[2] = 32'hA5A5_A5A5;
    req_mode[2]  = LW;
    @(negedge clk);
    req_valid[2] = 1'b0;
    chk("l3_wait_ready", 32'(req_ready[2]), 32'd0);
    rst[2] = 1'b1;
    @(negedge clk);
    rst[2] = 1'b0;
    chk("l3_rstw_ready", 32'(req_ready[2]), 32'd1);
    chk("l3_rstw_valid", 32'(rsp_valid[2]), 32'd0);
    chk("l3_rstw_rdata", rsp_rdata[2], 32'd0);
    chk("l3_rstw_err", 32'(rsp_err[2]), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("l3_no_late_rsp_%0d", k), 32'(rsp_valid[2]), 32'd0);
    end
    run_req(2, 1'b0, 32'h20, 32'h0, LW, rd, er, lat);
    chk("l3_lw20_after_rst", rd, 32'h0);

    // LATENCY=3: reset while a store response is pending keeps the write.
    req_valid[2] = 1'b1;
    req_we[2]    = 1'b1;
    req_addr[2]  = 32'h28;
    req_wdata[2] = 32'h1357_2468;
    req_mode[2]  = LW;
    rsp_ready[2] = 1'b0;
    @(negedge clk);
    req_valid[2] = 1'b0;
    n = 1;
    while (!rsp_valid[2] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("l3_resp_latency", 32'(n), 32'd3);
    rst[2]       = 1'b1;
    rsp_ready[2] = 1'b1;
    @(negedge clk);
    rst[2] = 1'b0;
    chk("l3_rstr_valid", 32'(rsp_valid[2]), 32'd0);
    chk("l3_rstr_ready", 32'(req_ready[2]), 32'd1);
    run_req(2, 1'b0, 32'h28, 32'h0, LW, rd, er, lat);
    chk("l3_lw28_committed", rd, 32'h1357_2468);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
